// File: rtl/switch_pkg.sv
// Shared constants and types for the address-split switch and its front-end arbiter.
package switch_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAX_BURST_DEF  = 4;

  // Address split point used by the downstream switch; the arbiter never looks at it.
  localparam logic [7:0] ADDR_DIV = 8'h3F;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/switch_rr_arbiter_if.sv
// Requester-side handshake and switch-side beat bus of the round-robin arbiter.
// Requester i owns slice [i*ADDR_WIDTH +: ADDR_WIDTH] of req_addr (same for req_data).
interface switch_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          sw_valid;
  logic [ADDR_WIDTH-1:0]         sw_addr;
  logic [DATA_WIDTH-1:0]         sw_data;

  // Requesters plus the switch observing the output beat.
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, sw_valid, sw_addr, sw_data
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, sw_valid, sw_addr, sw_data
  );

endinterface

// File: rtl/switch_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request searching upward from last+1 with wrap.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               found,
  output logic [IW-1:0]      idx
);

  // Walk offsets 1..NUM_REQ so the last owner is checked last; first hit wins.
  always_comb begin
    int          j;
    logic [IW-1:0] sel;
    found = 1'b0;
    idx   = last;
    j     = 0;
    sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j   = (int'(last) + k) % NUM_REQ;
      sel = IW'(j);
      if (!found && req[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/switch_rr_arbiter.sv
// Round-robin arbiter sharing the switch input port among NUM_REQ requesters.
// An owner keeps the grant for up to MAX_BURST beats; each re-grant costs one
// IDLE bubble. Outputs to the switch are registered.
module switch_rr_arbiter
  import switch_pkg::*;
#(
  parameter  int NUM_REQ    = NUM_REQ_DEF,
  parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int MAX_BURST  = MAX_BURST_DEF,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  switch_rr_arbiter_if.slave  bus,
  output logic [IW-1:0]       grant_id,
  output logic                busy
);

  arb_state_t state, state_nxt;
  logic [IW-1:0] gid_nxt;
  logic [CW-1:0] burst_cnt, cnt_nxt;

  logic          pick_found;
  logic [IW-1:0] pick_idx;

  logic [NUM_REQ-1:0]                 ready;
  logic                               accept;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_v;

  assign addr_v = bus.req_addr;
  assign data_v = bus.req_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .last  (grant_id),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Ready depends only on state/owner so a requester can never loop valid into ready.
  always_comb begin
    ready = '0;
    if (en && state == GRANT) ready[grant_id] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign accept        = ready[grant_id] & bus.req_valid[grant_id];
  assign busy          = (state == GRANT);

  // Next-state: arbitrate in IDLE, count beats or release in GRANT; en=0 holds everything.
  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    cnt_nxt   = burst_cnt;
    if (en) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state_nxt = GRANT;
            gid_nxt   = pick_idx;
            cnt_nxt   = '0;
          end
        end
        GRANT: begin
          if (accept) begin
            cnt_nxt = burst_cnt + 1'b1;
            if (burst_cnt == CW'(MAX_BURST - 1)) state_nxt = IDLE;
          end else begin
            // Owner dropped valid: give the port up without a beat.
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM, owner and burst counter registers; grant_id resets so requester 0 is first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      grant_id  <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= gid_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Switch-side beat register: one-cycle valid pulse per accepted beat, payload held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.sw_valid <= 1'b0;
      bus.sw_addr  <= '0;
      bus.sw_data  <= '0;
    end else begin
      bus.sw_valid <= accept;
      if (accept) begin
        bus.sw_addr <= addr_v[grant_id];
        bus.sw_data <= data_v[grant_id];
      end
    end
  end

endmodule

// File: tb/tb_switch_rr_arbiter.sv
// Self-checking bench for switch_rr_arbiter: table vectors, directed corner sequences,
// and random traffic against a behavioural reference model.
module tb_switch_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   grant_id;
  logic         busy;

  switch_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  switch_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int         m_busy, m_gid, m_cnt, m_swv;
  logic [7:0] m_swa;
  logic [15:0] m_swd;

  // ---------------- requester driver ----------------
  bit          want [N];
  bit          en_d;
  logic [7:0]  q    [N][$];
  logic [7:0]  cur_a[N];
  logic [N-1:0] vld, p_vld, p_acc, last_rdy;
  logic [7:0]  p_a  [N];
  logic [7:0]  seen [$];
  bit          rec;
  int          run_gid[$];
  int          run_len[$];
  bit          prev_swv;
  logic [1:0]  prev_gid;

  function automatic logic [15:0] dat_of(input int i, input logic [7:0] a);
    return {8'(i), a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_gid = N - 1; m_cnt = 0; m_swv = 0; m_swa = '0; m_swd = '0;
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    r = '0;
    if (en_d && m_busy != 0) r[m_gid] = 1'b1;
    return r;
  endfunction

  // One clock edge of the arbiter's rules, stated directly on integers.
  task automatic m_update(input bit e, input logic [N-1:0] v);
    if (!e) begin
      m_swv = 0;
      return;
    end
    if (m_busy == 0) begin
      m_swv = 0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_gid + k) % N;
        if (v[j]) begin
          m_gid = j; m_busy = 1; m_cnt = 0;
          break;
        end
      end
    end else if (v[m_gid]) begin
      m_swv = 1;
      m_swa = cur_a[m_gid];
      m_swd = dat_of(m_gid, cur_a[m_gid]);
      m_cnt++;
      if (m_cnt == MB) m_busy = 0;
    end else begin
      m_swv  = 0;
      m_busy = 0;
    end
  endtask

  task automatic clear_drv();
    for (int i = 0; i < N; i++) begin
      want[i] = 0; q[i].delete(); cur_a[i] = '0; p_a[i] = '0;
    end
    vld = '0; p_vld = '0; p_acc = '0; last_rdy = '0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; en = 1'b0; en_d = 1'b0;
    clear_drv();
    m_reset();
    #1;
    chk("rst_swv",   32'(bus.sw_valid), 0);
    chk("rst_swa",   32'(bus.sw_addr),  0);
    chk("rst_swd",   32'(bus.sw_data),  0);
    chk("rst_gid",   32'(grant_id),     N - 1);
    chk("rst_busy",  32'(busy),         0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rstn = 1'b1; en_d = 1'b1;
  endtask

  // One cycle: drive at negedge, check ready, clock, update model, check registered outputs.
  task automatic step();
    logic [N-1:0] exp_rdy, acc;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      vld[i] = want[i] && (q[i].size() > 0);
      if (vld[i]) cur_a[i] = q[i][0];
      if (p_vld[i] && !p_acc[i] && vld[i]) chk("hold_addr", 32'(cur_a[i]), 32'(p_a[i]));
      bus.req_addr[i*AW +: AW] = cur_a[i];
      bus.req_data[i*DW +: DW] = dat_of(i, cur_a[i]);
    end
    bus.req_valid = vld;
    en = en_d;
    #1;
    exp_rdy = m_ready();
    last_rdy = bus.req_ready;
    chk("ready", 32'(bus.req_ready), 32'(exp_rdy));
    acc = exp_rdy & vld;
    @(posedge clk);
    m_update(en_d, vld);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(q[i].pop_front());
      p_a[i] = cur_a[i];
    end
    p_vld = vld; p_acc = acc;
    #1;
    chk("sw_valid", 32'(bus.sw_valid), 32'(m_swv));
    chk("sw_addr",  32'(bus.sw_addr),  32'(m_swa));
    chk("sw_data",  32'(bus.sw_data),  32'(m_swd));
    chk("busy",     32'(busy),         32'(m_busy));
    chk("grant_id", 32'(grant_id),     32'(m_gid));
    if (bus.sw_valid) seen.push_back(bus.sw_addr);
    if (rec && bus.sw_valid) begin
      if (prev_swv && grant_id == prev_gid) run_len[run_len.size()-1]++;
      else begin run_gid.push_back(int'(grant_id)); run_len.push_back(1); end
    end
    prev_swv = bus.sw_valid; prev_gid = grant_id;
  endtask

  typedef struct {
    bit         en;
    logic [3:0] vld;
    logic [7:0] a;
    logic [3:0] rdy;
    bit         swv;
    logic [7:0] swa;
    bit         busy;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Requester 0 alone, six beats 0x10..0x15: burst of 4, bubble, re-grant, 2 more, release.
    tbl[0] = '{1'b1, 4'h1, 8'h10, 4'h0, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[1] = '{1'b1, 4'h1, 8'h10, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0};
    tbl[2] = '{1'b1, 4'h1, 8'h11, 4'h1, 1'b1, 8'h11, 1'b1, 2'd0};
    tbl[3] = '{1'b1, 4'h1, 8'h12, 4'h1, 1'b1, 8'h12, 1'b1, 2'd0};
    tbl[4] = '{1'b1, 4'h1, 8'h13, 4'h1, 1'b1, 8'h13, 1'b0, 2'd0};
    tbl[5] = '{1'b1, 4'h1, 8'h14, 4'h0, 1'b0, 8'h13, 1'b1, 2'd0};
    tbl[6] = '{1'b1, 4'h1, 8'h14, 4'h1, 1'b1, 8'h14, 1'b1, 2'd0};
    tbl[7] = '{1'b1, 4'h1, 8'h15, 4'h1, 1'b1, 8'h15, 1'b1, 2'd0};
    tbl[8] = '{1'b1, 4'h0, 8'h15, 4'h1, 1'b0, 8'h15, 1'b0, 2'd0};
    tbl[9] = '{1'b1, 4'h0, 8'h15, 4'h0, 1'b0, 8'h15, 1'b0, 2'd0};

    rec = 0; prev_swv = 0; prev_gid = '0;
    clear_drv();
    m_reset();

    // ---- table vectors ----
    do_reset();
    foreach (tbl[r]) begin
      @(negedge clk);
      en = tbl[r].en;
      bus.req_valid = tbl[r].vld;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.req_addr[0 +: AW] = tbl[r].a;
      bus.req_data[0 +: DW] = dat_of(0, tbl[r].a);
      #1;
      chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[r].rdy));
      @(posedge clk);
      #1;
      chk("tbl_swv",  32'(bus.sw_valid), 32'(tbl[r].swv));
      chk("tbl_swa",  32'(bus.sw_addr),  32'(tbl[r].swa));
      chk("tbl_swd",  32'(bus.sw_data),  (tbl[r].swa == 8'h00) ? 32'h0 : 32'(dat_of(0, tbl[r].swa)));
      chk("tbl_busy", 32'(busy),         32'(tbl[r].busy));
      chk("tbl_gid",  32'(grant_id),     32'(tbl[r].gid));
    end

    // ---- all four requesters saturating: order 0,1,2,3,0, four beats each ----
    do_reset();
    for (int i = 0; i < N; i++) begin
      want[i] = 1;
      for (int k = 0; k < 8; k++) q[i].push_back(8'(i * 8'h40 + k));
    end
    rec = 1; prev_swv = 0;
    run_gid.delete(); run_len.delete();
    for (int c = 0; c < 26; c++) step();
    rec = 0;
    chk("rr_nruns", 32'(run_len.size() >= 5), 1);
    for (int k = 0; k < 5 && k < run_len.size(); k++) begin
      chk("rr_gid", 32'(run_gid[k]), 32'(k % N));
      chk("rr_len", 32'(run_len[k]), MB);
    end

    // ---- early release: req 2 sends two beats and drops while req 3 waits ----
    do_reset();
    want[2] = 1; q[2].push_back(8'h20); q[2].push_back(8'h21);
    want[3] = 1; for (int k = 0; k < 4; k++) q[3].push_back(8'h30 + 8'(k));
    step();
    chk("er_gid2", 32'(grant_id), 2);
    step(); step();
    step();
    chk("er_busy_fall", 32'(busy), 0);
    chk("er_gid_hold", 32'(grant_id), 2);
    step();
    chk("er_gid3", 32'(grant_id), 3);
    chk("er_busy3", 32'(busy), 1);
    q[2].push_back(8'h22);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("er_noready2", 32'(last_rdy[2]), 0);
    end

    // ---- mid-burst freeze on requester 1 ----
    do_reset();
    want[1] = 1;
    q[1].push_back(8'h3F); q[1].push_back(8'h40); q[1].push_back(8'h41); q[1].push_back(8'h42);
    seen.delete();
    step(); step();
    en_d = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("frz_ready", 32'(last_rdy), 0);
      chk("frz_swv", 32'(bus.sw_valid), 0);
    end
    en_d = 1;
    step(); step(); step();
    chk("frz_nbeats", 32'(seen.size()), 4);
    if (seen.size() == 4) begin
      chk("frz_a0", 32'(seen[0]), 32'h3F);
      chk("frz_a1", 32'(seen[1]), 32'h40);
      chk("frz_a3", 32'(seen[3]), 32'h42);
    end
    step();
    chk("frz_done", 32'(busy), 0);

    // ---- asynchronous reset mid-burst of requester 3 ----
    do_reset();
    want[3] = 1; for (int k = 0; k < 4; k++) q[3].push_back(8'h70 + 8'(k));
    step(); step();
    @(negedge clk);
    bus.req_valid = 4'h8;
    bus.req_addr[3*AW +: AW] = 8'h71;
    #2 rstn = 1'b0;
    #1;
    chk("arst_swv",   32'(bus.sw_valid), 0);
    chk("arst_swa",   32'(bus.sw_addr),  0);
    chk("arst_swd",   32'(bus.sw_data),  0);
    chk("arst_ready", 32'(bus.req_ready), 0);
    chk("arst_gid",   32'(grant_id),     N - 1);
    clear_drv();
    m_reset();
    @(negedge clk);
    rstn = 1'b1; en_d = 1'b1;
    want[0] = 1; q[0].push_back(8'h01);
    want[3] = 1; q[3].push_back(8'h75);
    step();
    chk("arst_prio0", 32'(grant_id), 0);
    step(); step(); step();

    // ---- random traffic against the model ----
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 2) q[i].push_back(8'($urandom));
        if (p_vld[i] && !p_acc[i]) want[i] = ($urandom_range(0, 9) < 9);
        else                       want[i] = ($urandom_range(0, 9) < 6);
      end
      en_d = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_rr_arbiter.md
Name: switch_rr_arbiter

Overview:
- Shares the single input port of the address-split switch between NUM_REQ independent requesters.
- Round-robin arbitration with bounded bursts: an owner keeps the grant for up to MAX_BURST consecutive beats.
- Each requester uses a valid/ready handshake; the switch side is driven as registered valid/addr/data.
- Sits directly upstream of the switch and never reorders beats within one requester.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- ADDR_WIDTH, 8: address width, matching the switch.
- DATA_WIDTH, 16: data width, matching the switch.
- MAX_BURST, 4: maximum beats per grant; must be ≥1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset, asynchronous assert, active-low.
- en  in  1  global enable; low freezes the arbiter.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed data, sliced the same way.
- req_ready  out  NUM_REQ  per-requester accept.
- sw_valid  out  1  beat valid to switch.
- sw_addr  out  ADDR_WIDTH  beat address to switch.
- sw_data  out  DATA_WIDTH  beat data to switch.
- grant_id  out  $clog2(NUM_REQ)  current or last owner index.
- busy  out  1  high while state is GRANT.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; sw_valid=0, sw_addr=0, sw_data=0.
  - grant_id=NUM_REQ-1, so requester 0 has first priority.
  - burst_cnt=0, req_ready all 0.
- FSM IDLE:
  - If en and any req_valid, pick the first asserted index searching upward from (grant_id+1) mod NUM_REQ with wrap.
  - Register the pick into grant_id; move to GRANT; clear burst_cnt.
  - No requester is ready in IDLE, so every grant change costs one bubble cycle.
- FSM GRANT:
  - req_ready[i] = en && (state==GRANT) && (grant_id==i); combinational from state only, never from req_valid.
  - Beat accepted when req_valid[grant_id] && req_ready[grant_id].
  - On an accepted beat: sw_valid<=1, sw_addr/sw_data <= owner slice; burst_cnt++.
  - If burst_cnt==MAX_BURST-1 at acceptance, next state is IDLE (burst limit reached).
  - If en && !req_valid[grant_id], the owner released early: next state IDLE, no beat, burst_cnt unchanged.
- Output timing:
  - sw_valid is high exactly one cycle per accepted beat, on the cycle after acceptance.
  - Otherwise sw_valid=0 and sw_addr/sw_data hold their last values.
- Latency:
  - From an idle arbiter, req_valid at edge N gives ready at N+1 and sw_valid at N+2.
  - Back-to-back beats within a burst run at one per cycle.
- en=0:
  - All req_ready=0; state, grant_id and burst_cnt frozen; sw_valid<=0.
  - Neither early release nor arbitration is evaluated.
- Requester rule: addr/data must be held stable while valid && !ready; the bench asserts this.
- Only the owner can move state. Non-owner valids are ignored until the next IDLE.
- Reset mid-burst: outputs return to reset values immediately. Partial bursts are not resumed.
- The arbiter does not interpret addresses; address-range routing stays in the switch.

Decomposition:
- Shared package switch_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults, and the switch ADDR_DIV constant (0x3F);
  - state enum arb_state_t {IDLE, GRANT};
  - the NUM_REQ default.
- One sub-module, rr_pick: combinational rotating-priority encoder.
  - Inputs: req vector and last grant.
  - Outputs: found flag and index.
- The top holds the FSM, burst counter and output registers.

Test Plan:
- Reset, then requester 0 alone sends 6 beats, addrs 0x10..0x15:
  - sw_valid pulses for 0x10-0x13;
  - one bubble cycle with busy=0;
  - re-grant to 0, then 0x14, 0x15;
  - first sw_valid exactly 2 cycles after req_valid.
- All four requesters continuously valid, 4-beat bursts each:
  - grant_id order 0,1,2,3,0;
  - each grant delivers exactly 4 sw_valid beats in consecutive cycles.
- Early release:
  - requester 2 is granted, sends 2 beats, drops valid while requester 3 is waiting;
  - busy falls the next cycle, grant_id becomes 3 one cycle later;
  - requester 2 gets no further ready.
- Mid-burst freeze: drop en for 3 cycles after beat 1 of requester 1 (addrs 0x3F, 0x40, 0x41, 0x42):
  - no ready and no sw_valid during the freeze;
  - burst resumes with 0x40 and completes 4 beats total;
  - sw_addr passes 0x3F and 0x40 unchanged.
- Async reset mid-burst:
  - assert rstn=0 off-edge during requester 3's beat 2;
  - sw_valid=0, sw_addr=0, sw_data=0 and req_ready=0 immediately;
  - after release, requester 0 wins priority over a simultaneous requester 3.
